reg_bank_wb: RTL and testbench
==============================

// Module: reg_bank_wb
// PURPOSE
//  4-entry x 32-bit register bank with a one-entry write-back staging buffer.
//  Sits directly upstream of the 5-bit-select register read mux; R00..R03 drive that mux's inputs.
//  Writes arrive on a valid/ready handshake, are staged one cycle, then commit unless held.
// PARAMETERS
//  DATA_W   32  register/data width
//  ADDR_W   5   write address width (matches read-mux select width)
//  NREGS    4   implemented registers; fixed at 4 by the R00..R03 ports
//  ZERO_R0  1   1: R00 hardwired to 0, writes to addr 0 dropped silently
//  CNT_W    16  commit counter width
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  wr_valid   in   1       write request valid
//  wr_ready   out  1       write request accepted when wr_valid&wr_ready
//  wr_addr    in   ADDR_W  destination register
//  wr_data    in   DATA_W  write data
//  hold       in   1       1: staged write must not commit this cycle
//  R00..R03   out  DATA_W  register contents to the read mux
//  pend_valid out  1       staging buffer occupied
//  err_addr   out  1       1-cycle pulse: staged write to addr >= NREGS was dropped
//  wr_count   out  CNT_W   number of committed writes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async, any time): regs=0, pend_valid=0, err_addr=0, wr_count=0; staged write discarded.
//    wr_ready reads 1 out of reset.
//  - wr_ready = !pend_valid | !hold (combinational, no dependence on wr_valid).
//  - Accept: wr_valid&wr_ready -> next edge stages pend_addr/pend_data, pend_valid=1.
//  - Commit: pend_valid&!hold at edge -> reg[pend_addr]<=pend_data, wr_count+1, pend_valid cleared
//    unless a new write is accepted on the same edge.
//  - Accept and commit on the same edge: old entry commits, new entry is staged; full throughput 1 write/cycle.
//  - Latency: accept edge N, commit edge N+1 (no hold); R0x shows new value after edge N+1.
//  - hold with pend_valid=1: buffer frozen, wr_ready=0, no commit, no count.
//  - pend_addr >= NREGS on commit: no register changes, err_addr=1 for one cycle, wr_count still increments.
//  - pend_addr==0 with ZERO_R0=1: dropped, counts as committed, no err_addr; R00 stays 0.
//  - Back-to-back writes to same register: commit in acceptance order; last one wins.
//  - wr_count wraps from 2^CNT_W-1 to 0 with no flag.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    R0x = pend_data when pend_valid & pend_addr==x (x legal, not zero-reg), else stored value.
//    Staged value visible in the accept+1 cycle, including while held.
//  WB_BYPASS_EN undefined:
//    R0x = stored registers only; staged data is invisible until commit.
// STRUCTURE
//  - Package reg_bank_pkg:
//    DATA_W, ADDR_W, NREGS constants;
//    typedef wb_req_t {addr, data};
//    REG_R00..REG_R03 address constants.
//  - Sub-module wb_stage: one-entry staging register with the valid/ready/hold logic.
//    Outputs pend_valid, pend_addr, pend_data and a commit strobe.
//  - Top: register array, address decode, err_addr/wr_count, optional bypass mux.
// TESTING
//  1. Reset: assert reset mid-stage with pending write to 2 -> R00..R03=0, pend_valid=0, wr_count=0, wr_ready=1.
//  2. Single write: addr=3, data=0xDEADBEEF, hold=0.
//     -> R03=0xDEADBEEF two edges after request, wr_count=1.
//  3. Streaming writes 1,2,3,1 (data 0x11,0x22,0x33,0x44) with wr_valid held high:
//     -> wr_ready stays 1, final R01=0x44, R02=0x22, R03=0x33, wr_count=4.
//  4. Hold: stage addr=2 data=0x5, hold=1 for 3 cycles:
//     -> wr_ready=0, R02 unchanged (bypass off) or 0x5 (WB_BYPASS_EN);
//     -> release hold -> R02=0x5, wr_count+1.
//  5. Illegal/zero address: write addr=7 -> err_addr pulses 1 cycle, regs unchanged;
//     write addr=0 data=0xFF -> R00=0, no err_addr.
//  6. Counter wrap: preload via 2^CNT_W commits (or CNT_W=4 build, 16 commits) -> wr_count returns to 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the reg_bank_wb register bank.
// Optional feature macro: WB_BYPASS_EN (see reg_bank_wb.sv).
package reg_bank_pkg;

  localparam int DATA_W = 32;  // register/data width
  localparam int ADDR_W = 5;   // write address width, matches read-mux select
  localparam int NREGS  = 4;   // implemented registers (R00..R03)
  localparam int IDX_W  = 2;   // bits needed to index NREGS registers

  // Staged write request: destination address plus data.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  localparam logic [ADDR_W-1:0] REG_R00 = 5'd0;
  localparam logic [ADDR_W-1:0] REG_R01 = 5'd1;
  localparam logic [ADDR_W-1:0] REG_R02 = 5'd2;
  localparam logic [ADDR_W-1:0] REG_R03 = 5'd3;

  // True when the address selects an implemented register.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(NREGS);
  endfunction

endpackage

// File: rtl/reg_bank_wb_if.sv
// Write-request bus for reg_bank_wb: valid/ready handshake plus commit hold.
// Optional feature macro: none.
interface reg_bank_wb_if;

  logic                            wr_valid;
  logic                            wr_ready;
  logic [reg_bank_pkg::ADDR_W-1:0] wr_addr;
  logic [reg_bank_pkg::DATA_W-1:0] wr_data;
  logic                            hold;

  // Requester side drives the write and the hold.
  modport master (
    output wr_valid, wr_addr, wr_data, hold,
    input  wr_ready
  );

  // Register bank side answers with ready.
  modport slave (
    input  wr_valid, wr_addr, wr_data, hold,
    output wr_ready
  );

endinterface

// File: rtl/reg_bank_wb_stage.sv
// One-entry write-back staging buffer: accepts a write, holds it one cycle,
// then releases it as a commit unless hold is asserted.
// Optional feature macro: none.
module wb_stage
  import reg_bank_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    wr_valid,
  input  wb_req_t wr_req,
  input  logic    hold,
  output logic    wr_ready,
  output logic    pend_valid,
  output wb_req_t pend_req,
  output logic    commit
);

  logic    pend_valid_q, pend_valid_d;
  wb_req_t pend_req_q, pend_req_d;
  logic    accept;

  // Handshake, commit strobe and next buffer contents; a new accept on the
  // commit edge refills the slot so the buffer streams one write per cycle.
  always_comb begin
    wr_ready     = !pend_valid_q || !hold;
    accept       = wr_valid && wr_ready;
    commit       = pend_valid_q && !hold;
    pend_valid_d = pend_valid_q;
    pend_req_d   = pend_req_q;
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_req_d   = wr_req;
    end else if (commit) begin
      pend_valid_d = 1'b0;
    end
  end

  // Buffer state; reset discards any staged write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_req_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_req_q   <= pend_req_d;
    end
  end

  assign pend_valid = pend_valid_q;
  assign pend_req   = pend_req_q;

endmodule

// File: rtl/reg_bank_wb.sv
// 4 x 32-bit register bank fed through a one-entry write-back staging buffer.
// Optional feature macro: WB_BYPASS_EN -- when defined, a staged write to a
// writable register is forwarded onto that register's output before commit.
module reg_bank_wb
  import reg_bank_pkg::*;
#(
  parameter bit ZERO_R0 = 1'b1,  // 1: R00 reads 0, writes to it are dropped
  parameter int CNT_W   = 16     // commit counter width
) (
  input  logic               clk,
  input  logic               reset,
  reg_bank_wb_if.slave       bus,
  output logic [DATA_W-1:0]  R00,
  output logic [DATA_W-1:0]  R01,
  output logic [DATA_W-1:0]  R02,
  output logic [DATA_W-1:0]  R03,
  output logic               pend_valid,
  output logic               err_addr,
  output logic [CNT_W-1:0]   wr_count
);

  wb_req_t           wr_req;
  wb_req_t           pend_req;
  logic              commit;
  logic              legal;
  logic              zero_drop;
  logic [IDX_W-1:0]  pend_idx;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              err_addr_q, err_addr_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [DATA_W-1:0] rd_data [NREGS];

  // Pack the incoming bus fields into a request.
  always_comb begin
    wr_req      = '0;
    wr_req.addr = bus.wr_addr;
    wr_req.data = bus.wr_data;
  end

  wb_stage u_stage (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (bus.wr_valid),
    .wr_req     (wr_req),
    .hold       (bus.hold),
    .wr_ready   (bus.wr_ready),
    .pend_valid (pend_valid),
    .pend_req   (pend_req),
    .commit     (commit)
  );

  assign pend_idx  = pend_req.addr[IDX_W-1:0];
  assign legal     = addr_legal(pend_req.addr);
  assign zero_drop = ZERO_R0 && (pend_req.addr == REG_R00);

  // Commit decode: illegal addresses flag an error, zero-register writes
  // vanish quietly, and every commit is counted regardless of outcome.
  always_comb begin
    regs_d     = regs_q;
    err_addr_d = 1'b0;
    wr_count_d = wr_count_q;
    if (commit) begin
      wr_count_d = wr_count_q + CNT_W'(1);
      if (!legal) begin
        err_addr_d = 1'b1;
      end else if (!zero_drop) begin
        regs_d[pend_idx] = pend_req.data;
      end
    end
  end

  // Register array, error pulse and commit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q     <= '{default: '0};
      err_addr_q <= 1'b0;
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      err_addr_q <= err_addr_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Read-side view of each register, optionally forwarding the staged write.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_rd
`ifdef WB_BYPASS_EN
    assign rd_data[gi] = (pend_valid && (pend_req.addr == ADDR_W'(gi)) &&
                          !(ZERO_R0 && (gi == 0))) ? pend_req.data : regs_q[gi];
`else
    assign rd_data[gi] = regs_q[gi];
`endif
  end

  assign R00      = rd_data[0];
  assign R01      = rd_data[1];
  assign R02      = rd_data[2];
  assign R03      = rd_data[3];
  assign err_addr = err_addr_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed testbench for reg_bank_wb (built with a 4-bit commit counter so
// the wrap case stays short). Honours WB_BYPASS_EN when defined.
module tb_reg_bank_wb;

    import reg_bank_pkg::*;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] r00, r01, r02, r03;
    logic        pend_valid, err_addr;
    logic [3:0]  wr_count;
    int          errors = 0;
    int          checks = 0;

    reg_bank_wb_if bus ();

    reg_bank_wb #(.ZERO_R0(1'b1), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .R00        (r00),
        .R01        (r01),
        .R02        (r02),
        .R03        (r03),
        .pend_valid (pend_valid),
        .err_addr   (err_addr),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0]  s_addr [4];
        logic [31:0] s_data [4];
        s_addr = '{5'd1, 5'd2, 5'd3, 5'd1};
        s_data = '{32'h11, 32'h22, 32'h33, 32'h44};

        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.hold     = 1'b0;

        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (r00 !== 32'h0) begin errors++; $error("FAIL rst_r00: observed=%0h", r00); end
        checks++; if (r03 !== 32'h0) begin errors++; $error("FAIL rst_r03: observed=%0h", r03); end
        checks++; if (pend_valid !== 1'b0) begin errors++; $error("FAIL rst_pend: observed=%0h", pend_valid); end
        checks++; if (wr_count !== 4'd0) begin errors++; $error("FAIL rst_cnt: observed=%0h", wr_count); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $error("FAIL rst_ready: observed=%0h", bus.wr_ready); end
        checks++; if (err_addr !== 1'b0) begin errors++; $error("FAIL rst_err: observed=%0h", err_addr); end

        bus.wr_valid = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'hAAAA_5555;
        $display("wr addr=2 data=aaaa5555 (to be reset)");
        tick();
        bus.wr_valid = 1'b0; bus.hold = 1'b1;
        checks++; if (pend_valid !== 1'b1) begin errors++; $error("FAIL mid_pend_set: observed=%0h", pend_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (pend_valid !== 1'b0) begin errors++; $error("FAIL mid_pend_clr: observed=%0h", pend_valid); end
        checks++; if (r02 !== 32'h0) begin errors++; $error("FAIL mid_r02: observed=%0h", r02); end
        checks++; if (wr_count !== 4'd0) begin errors++; $error("FAIL mid_cnt: observed=%0h", wr_count); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $error("FAIL mid_ready: observed=%0h", bus.wr_ready); end
        tick();
        reset = 1'b0; bus.hold = 1'b0;
        tick();
        checks++; if (r02 !== 32'h0) begin errors++; $error("FAIL mid_r02_after: observed=%0h", r02); end
        checks++; if (wr_count !== 4'd0) begin errors++; $error("FAIL mid_cnt_after: observed=%0h", wr_count); end

        bus.wr_valid = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hDEAD_BEEF;
        $display("wr addr=3 data=deadbeef");
        tick();
        bus.wr_valid = 1'b0;
        checks++; if (pend_valid !== 1'b1) begin errors++; $error("FAIL single_pend: observed=%0h", pend_valid); end
        checks++; if (r03 !== (BYP ? 32'hDEAD_BEEF : 32'h0)) begin errors++; $error("FAIL single_r03_staged: observed=%0h", r03); end
        tick();
        checks++; if (r03 !== 32'hDEAD_BEEF) begin errors++; $error("FAIL single_r03: observed=%0h", r03); end
        checks++; if (wr_count !== 4'd1) begin errors++; $error("FAIL single_cnt: observed=%0h", wr_count); end
        checks++; if (pend_valid !== 1'b0) begin errors++; $error("FAIL single_pend_clr: observed=%0h", pend_valid); end

        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = s_addr[i]; bus.wr_data = s_data[i];
            #1;
            checks++; if (bus.wr_ready !== 1'b1) begin errors++; $error("FAIL stream_ready: observed=%0h", bus.wr_ready); end
            $display("wr addr=%0d data=%0h (stream)", s_addr[i], s_data[i]);
            tick();
        end
        bus.wr_valid = 1'b0;
        checks++; if (wr_count !== 4'd4) begin errors++; $error("FAIL stream_cnt_mid: observed=%0h", wr_count); end
        checks++; if (pend_valid !== 1'b1) begin errors++; $error("FAIL stream_pend_mid: observed=%0h", pend_valid); end
        tick();
        checks++; if (r01 !== 32'h44) begin errors++; $error("FAIL stream_r01: observed=%0h", r01); end
        checks++; if (r02 !== 32'h22) begin errors++; $error("FAIL stream_r02: observed=%0h", r02); end
        checks++; if (r03 !== 32'h33) begin errors++; $error("FAIL stream_r03: observed=%0h", r03); end
        checks++; if (wr_count !== 4'd5) begin errors++; $error("FAIL stream_cnt: observed=%0h", wr_count); end

        bus.wr_valid = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'h5;
        $display("wr addr=2 data=5 (held)");
        tick();
        bus.wr_valid = 1'b0; bus.hold = 1'b1;
        #1;
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $error("FAIL hold_ready: observed=%0h", bus.wr_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (r02 !== (BYP ? 32'h5 : 32'h22)) begin errors++; $error("FAIL hold_r02: observed=%0h", r02); end
            checks++; if (wr_count !== 4'd5) begin errors++; $error("FAIL hold_cnt: observed=%0h", wr_count); end
            checks++; if (pend_valid !== 1'b1) begin errors++; $error("FAIL hold_pend: observed=%0h", pend_valid); end
        end
        bus.hold = 1'b0;
        #1;
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $error("FAIL release_ready: observed=%0h", bus.wr_ready); end
        tick();
        checks++; if (r02 !== 32'h5) begin errors++; $error("FAIL release_r02: observed=%0h", r02); end
        checks++; if (wr_count !== 4'd6) begin errors++; $error("FAIL release_cnt: observed=%0h", wr_count); end
        checks++; if (pend_valid !== 1'b0) begin errors++; $error("FAIL release_pend: observed=%0h", pend_valid); end

        bus.wr_valid = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h77;
        $display("wr addr=7 data=77 (illegal)");
        tick();
        bus.wr_valid = 1'b0;
        checks++; if (err_addr !== 1'b0) begin errors++; $error("FAIL ill_err_early: observed=%0h", err_addr); end
        tick();
        checks++; if (err_addr !== 1'b1) begin errors++; $error("FAIL ill_err: observed=%0h", err_addr); end
        checks++; if (wr_count !== 4'd7) begin errors++; $error("FAIL ill_cnt: observed=%0h", wr_count); end
        checks++; if (r01 !== 32'h44) begin errors++; $error("FAIL ill_r01: observed=%0h", r01); end
        checks++; if (r02 !== 32'h5) begin errors++; $error("FAIL ill_r02: observed=%0h", r02); end
        checks++; if (r03 !== 32'h33) begin errors++; $error("FAIL ill_r03: observed=%0h", r03); end
        tick();
        checks++; if (err_addr !== 1'b0) begin errors++; $error("FAIL ill_err_clr: observed=%0h", err_addr); end

        bus.wr_valid = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFF;
        $display("wr addr=0 data=ff (zero reg)");
        tick();
        bus.wr_valid = 1'b0;
        checks++; if (r00 !== 32'h0) begin errors++; $error("FAIL zero_r00_staged: observed=%0h", r00); end
        tick();
        checks++; if (r00 !== 32'h0) begin errors++; $error("FAIL zero_r00: observed=%0h", r00); end
        checks++; if (err_addr !== 1'b0) begin errors++; $error("FAIL zero_err: observed=%0h", err_addr); end
        checks++; if (wr_count !== 4'd8) begin errors++; $error("FAIL zero_cnt: observed=%0h", wr_count); end

        for (int i = 0; i < 8; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = 32'h100 + 32'(i);
            #1;
            checks++; if (bus.wr_ready !== 1'b1) begin errors++; $error("FAIL wrap_ready: observed=%0h", bus.wr_ready); end
            $display("wr addr=1 data=%0h (wrap)", 32'h100 + 32'(i));
            tick();
        end
        bus.wr_valid = 1'b0;
        checks++; if (wr_count !== 4'd15) begin errors++; $error("FAIL wrap_cnt_max: observed=%0h", wr_count); end
        tick();
        checks++; if (wr_count !== 4'd0) begin errors++; $error("FAIL wrap_cnt_zero: observed=%0h", wr_count); end
        checks++; if (r01 !== 32'h107) begin errors++; $error("FAIL wrap_r01: observed=%0h", r01); end
        checks++; if (err_addr !== 1'b0) begin errors++; $error("FAIL wrap_err: observed=%0h", err_addr); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
